// File: rtl/sp_ram_be.sv
// Single-port RAM with per-byte write enables, selectable read-during-write result,
// optional output register and a word-per-cycle clear engine that runs after reset.
module sp_ram_be #(
    parameter int DATA_W   = 16,
    parameter int ADDR_W   = 3,
    parameter int DEPTH    = 8,
    parameter int RDW_MODE = 0,
    parameter int OUT_REG  = 0,
    localparam int BE_W    = DATA_W / 8
) (
    input  logic              wclk,
    input  logic              rst,
    input  logic              en,
    input  logic              we,
    input  logic [BE_W-1:0]   be,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] d_in,
    input  logic              clr,
    output logic [DATA_W-1:0] d_out,
    output logic              rd_valid,
    output logic              busy
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic {CLEAR, IDLE} state_t;

    state_t            state, state_n;
    logic [ADDR_W-1:0] cnt, cnt_n;
    logic [DATA_W-1:0] mem [DEPTH];

    logic [IDX_W-1:0]  idx, cnt_idx;
    logic              in_range, acc;
    logic [DATA_W-1:0] old_word, merged, result;
    logic [DATA_W-1:0] d_q;
    logic              v_q;

    assign idx      = addr[IDX_W-1:0];
    assign cnt_idx  = cnt[IDX_W-1:0];
    assign in_range = (int'(addr) < DEPTH);
    assign busy     = (state == CLEAR);
    assign acc      = (state == IDLE) && en && !clr;

    always_ff @(posedge wclk or posedge rst) begin
        if (rst) begin
            state <= CLEAR;
            cnt   <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        case (state)
            CLEAR: begin
                cnt_n = cnt + 1'b1;
                if (cnt == ADDR_W'(DEPTH - 1)) begin
                    state_n = IDLE;
                    cnt_n   = '0;
                end
            end
            IDLE: begin
                if (clr) begin
                    state_n = CLEAR;
                    cnt_n   = '0;
                end
            end
            default: begin
                state_n = CLEAR;
                cnt_n   = '0;
            end
        endcase
    end

    always_comb begin
        old_word = '0;
        if (in_range)
            old_word = mem[idx];
        merged = old_word;
        for (int unsigned i = 0; i < BE_W; i++)
            if (be[i])
                merged[8*i +: 8] = d_in[8*i +: 8];
        // Unimplemented addresses always return zero, whatever the access type.
        if (!in_range)
            result = '0;
        else if (we && (RDW_MODE == 1))
            result = merged;
        else
            result = old_word;
    end

    always_ff @(posedge wclk) begin
        if (state == CLEAR)
            mem[cnt_idx] <= '0;
        else if (acc && we && in_range)
            mem[idx] <= merged;
    end

    always_ff @(posedge wclk or posedge rst) begin
        if (rst) begin
            d_q <= '0;
            v_q <= 1'b0;
        end else begin
            v_q <= acc;
            if (acc)
                d_q <= result;
        end
    end

    generate
        if (OUT_REG != 0) begin : g_oreg
            logic [DATA_W-1:0] d_r;
            logic              v_r;
            always_ff @(posedge wclk or posedge rst) begin
                if (rst) begin
                    d_r <= '0;
                    v_r <= 1'b0;
                end else begin
                    d_r <= d_q;
                    v_r <= v_q;
                end
            end
            assign d_out    = d_r;
            assign rd_valid = v_r;
        end else begin : g_direct
            assign d_out    = d_q;
            assign rd_valid = v_q;
        end
    endgenerate

endmodule

// File: tb/tb_sp_ram_be.sv
// Directed bench: two default-geometry RAMs (read-first / write-first) on shared stimulus,
// plus a DEPTH=6 registered-output instance exercised on its own.
module tb_sp_ram_be;

    logic        wclk = 1'b0;
    logic        rst, en, we, clr;
    logic [1:0]  be;
    logic [2:0]  addr;
    logic [15:0] d_in;
    logic [15:0] d_out_a, d_out_b;
    logic        rd_valid_a, rd_valid_b, busy_a, busy_b;

    logic        c_rst, c_en, c_we, c_clr;
    logic [1:0]  c_be;
    logic [2:0]  c_addr;
    logic [15:0] c_d_in;
    logic [15:0] c_d_out;
    logic        c_rd_valid, c_busy;

    int n_cmp = 0;
    int n_err = 0;
    int cyc;

    always #5 wclk = ~wclk;

    sp_ram_be #(.DATA_W(16), .ADDR_W(3), .DEPTH(8), .RDW_MODE(0), .OUT_REG(0)) u_rf (
        .wclk(wclk), .rst(rst), .en(en), .we(we), .be(be), .addr(addr), .d_in(d_in),
        .clr(clr), .d_out(d_out_a), .rd_valid(rd_valid_a), .busy(busy_a));

    sp_ram_be #(.DATA_W(16), .ADDR_W(3), .DEPTH(8), .RDW_MODE(1), .OUT_REG(0)) u_wf (
        .wclk(wclk), .rst(rst), .en(en), .we(we), .be(be), .addr(addr), .d_in(d_in),
        .clr(clr), .d_out(d_out_b), .rd_valid(rd_valid_b), .busy(busy_b));

    sp_ram_be #(.DATA_W(16), .ADDR_W(3), .DEPTH(6), .RDW_MODE(0), .OUT_REG(1)) u_d6 (
        .wclk(wclk), .rst(c_rst), .en(c_en), .we(c_we), .be(c_be), .addr(c_addr), .d_in(c_d_in),
        .clr(c_clr), .d_out(c_d_out), .rd_valid(c_rd_valid), .busy(c_busy));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge wclk);
        #1;
    endtask

    task automatic acc_ab(input logic w, input logic [2:0] a, input logic [15:0] d, input logic [1:0] b);
        en = 1'b1; we = w; addr = a; d_in = d; be = b;
        step();
        en = 1'b0; we = 1'b0;
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; we = 1'b0; clr = 1'b0; be = '0; addr = '0; d_in = '0;
        c_rst = 1'b1; c_en = 1'b0; c_we = 1'b0; c_clr = 1'b0; c_be = '0; c_addr = '0; c_d_in = '0;

        step();
        step();
        check("rst_busy", busy_a, 1);
        check("rst_dout", d_out_a, 0);
        check("rst_valid", rd_valid_a, 0);

        rst = 1'b0;
        cyc = 0;
        while (cyc < 20) begin
            step();
            cyc++;
            if (!busy_a) break;
        end
        check("init_busy_len", cyc, 8);
        check("init_dout", d_out_a, 0);

        for (int i = 0; i < 8; i++) begin
            acc_ab(1'b0, 3'(i), 16'h0, 2'b00);
            check("init_rd_valid", rd_valid_a, 1);
            check("init_rd_data", d_out_a, 0);
        end
        step();
        check("idle_valid", rd_valid_a, 0);

        acc_ab(1'b1, 3'd0, 16'h1234, 2'b11);
        check("wr0_rf_old", d_out_a, 16'h0000);
        check("wr0_wf_new", d_out_b, 16'h1234);
        check("wr0_valid", rd_valid_a, 1);
        acc_ab(1'b1, 3'd1, 16'hBEEF, 2'b11);
        acc_ab(1'b1, 3'd2, 16'h00FF, 2'b11);
        acc_ab(1'b0, 3'd0, 16'h0, 2'b00);
        check("rd0", d_out_a, 16'h1234);
        acc_ab(1'b0, 3'd1, 16'h0, 2'b00);
        check("rd1", d_out_a, 16'hBEEF);
        acc_ab(1'b0, 3'd2, 16'h0, 2'b00);
        check("rd2", d_out_a, 16'h00FF);
        check("rd2_wf", d_out_b, 16'h00FF);
        step();
        check("hold_dout", d_out_a, 16'h00FF);
        check("hold_valid", rd_valid_a, 0);

        acc_ab(1'b1, 3'd5, 16'hAAAA, 2'b11);
        acc_ab(1'b1, 3'd5, 16'h5555, 2'b01);
        check("be01_rf", d_out_a, 16'hAAAA);
        check("be01_wf", d_out_b, 16'hAA55);
        acc_ab(1'b0, 3'd5, 16'h0, 2'b00);
        check("be01_rd", d_out_a, 16'hAA55);
        acc_ab(1'b1, 3'd5, 16'hFFFF, 2'b00);
        check("be00_valid", rd_valid_b, 1);
        check("be00_wf", d_out_b, 16'hAA55);
        acc_ab(1'b0, 3'd5, 16'h0, 2'b00);
        check("be00_rd", d_out_a, 16'hAA55);

        acc_ab(1'b1, 3'd3, 16'h1111, 2'b11);
        acc_ab(1'b1, 3'd3, 16'h2222, 2'b11);
        check("rdw_rf", d_out_a, 16'h1111);
        check("rdw_wf", d_out_b, 16'h2222);
        acc_ab(1'b0, 3'd3, 16'h0, 2'b00);
        check("rdw_rd_rf", d_out_a, 16'h2222);
        check("rdw_rd_wf", d_out_b, 16'h2222);

        // clr together with a read: read is dropped; clr kept high while busy is ignored.
        en = 1'b1; we = 1'b0; addr = 3'd3; clr = 1'b1;
        step();
        check("clr_drop_valid", rd_valid_a, 0);
        check("clr_busy", busy_a, 1);
        we = 1'b1; d_in = 16'hDEAD; be = 2'b11;
        step();
        check("busy_drop_valid", rd_valid_a, 0);
        check("busy_hold_dout", d_out_a, 16'h2222);
        step();
        clr = 1'b0; en = 1'b0; we = 1'b0;
        rst = 1'b1;
        #1;
        check("midclr_rst_dout", d_out_a, 0);
        check("midclr_rst_busy", busy_a, 1);
        step();
        rst = 1'b0;
        cyc = 0;
        while (cyc < 20) begin
            step();
            cyc++;
            if (!busy_a) break;
        end
        check("reclr_busy_len", cyc, 8);
        for (int i = 0; i < 8; i++) begin
            acc_ab(1'b0, 3'(i), 16'h0, 2'b00);
            check("reclr_rd", {15'd0, rd_valid_a, d_out_a}, 32'h10000);
        end

        c_rst = 1'b0;
        cyc = 0;
        while (cyc < 20) begin
            step();
            cyc++;
            if (!c_busy) break;
        end
        check("d6_busy_len", cyc, 6);
        check("d6_dout", c_d_out, 0);

        c_en = 1'b1; c_we = 1'b1; c_addr = 3'd7; c_d_in = 16'h4321; c_be = 2'b11;
        step();
        c_addr = 3'd5; c_d_in = 16'h9876;
        step();
        check("d6_wr7_valid", c_rd_valid, 1);
        check("d6_wr7_dout", c_d_out, 0);
        c_we = 1'b0; c_addr = 3'd5;
        step();
        check("d6_wr5_dout", c_d_out, 0);
        c_addr = 3'd7;
        step();
        check("d6_rd5_valid", c_rd_valid, 1);
        check("d6_rd5_dout", c_d_out, 16'h9876);
        c_en = 1'b0;
        step();
        check("d6_rd7_valid", c_rd_valid, 1);
        check("d6_rd7_dout", c_d_out, 0);
        step();
        check("d6_idle_valid", c_rd_valid, 0);

        c_en = 1'b1; c_addr = 3'd5;
        step();
        c_en = 1'b0;
        check("d6_lat_early", c_rd_valid, 0);
        step();
        check("d6_lat_valid", c_rd_valid, 1);
        check("d6_lat_dout", c_d_out, 16'h9876);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
